// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and instruction-class type.
// Also imported by the main control unit so opcode values stay in one place.
package riscv_pkg;

    typedef enum logic [1:0] {
        CLS_RTYPE = 2'd0,
        CLS_LOAD  = 2'd1,
        CLS_STORE = 2'd2,
        CLS_BEQ   = 2'd3
    } instr_class_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } loader_state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty told apart by the wrap bit.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push_s, do_pop_s;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[IW-1:0]];

    // Guarded push/pop and pointer advance
    always_comb begin
        do_push_s = push_i && !full_o;
        do_pop_s  = pop_i && !empty_o;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; reset flushes the queue
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[IW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Encodes R/LW/SW/BEQ descriptors into RV32I words, queues them and streams
// them into instruction memory from BASE_ADDR upward.
module instr_encode_loader
    import riscv_pkg::*;
#(
    parameter int             DEPTH     = 4,
    parameter int             AW        = 32,
    parameter logic [AW-1:0]  BASE_ADDR = {AW{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  instr_class_t      req_class,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [12:0]       req_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [AW-1:0]     imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              imm_misalign
);

    localparam int CW = $clog2(DEPTH) + 1;

    // BEQ drops imm[0]; branch targets are always halfword multiples
    function automatic logic [31:0] encode_instr(
        input instr_class_t cls,
        input logic [4:0]   rd,
        input logic [4:0]   rs1,
        input logic [4:0]   rs2,
        input logic [2:0]   f3,
        input logic [6:0]   f7,
        input logic [12:0]  imm
    );
        logic [31:0] w;
        w = 32'h0;
        case (cls)
            CLS_RTYPE: w = {f7, rs2, rs1, f3, rd, OP_RTYPE};
            CLS_LOAD:  w = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
            CLS_STORE: w = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
            CLS_BEQ:   w = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
            default:   w = 32'h0;
        endcase
        return w;
    endfunction

    loader_state_t   state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            finish_seen_q, finish_seen_d;
    logic            misalign_q, misalign_d;

    logic            push_s, pop_s, drain_s;
    logic [31:0]     enc_word_s, head_s;
    logic            fifo_full_s, fifo_empty_s;
    logic [CW-1:0]   fifo_count_s;

    assign req_ready    = !fifo_full_s;
    assign push_s       = req_valid && req_ready;
    assign enc_word_s   = encode_instr(req_class, req_rd, req_rs1, req_rs2,
                                       req_funct3, req_funct7, req_imm);
    assign imem_we      = (state_q == ST_RUN) && !fifo_empty_s;
    assign pop_s        = imem_we && imem_ready;
    assign imem_addr    = addr_q;
    assign done         = (state_q == ST_DONE);
    assign imm_misalign = misalign_q;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push_s),
        .wdata_i (enc_word_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Head word goes straight to the port; zero whenever no write is offered
    always_comb begin
        imem_wdata = 32'h0;
        if (imem_we) begin
            imem_wdata = head_s;
        end else begin
            imem_wdata = 32'h0;
        end
    end

    // Next state, address, finish tracking and sticky misalign flag
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        finish_seen_d = finish_seen_q;
        misalign_d    = misalign_q;
        // FIFO is empty after this edge: nothing arriving and nothing left behind
        drain_s = !push_s && (fifo_empty_s || ((fifo_count_s == CW'(1)) && pop_s));

        if (start) begin
            finish_seen_d = finish;
        end else if (finish) begin
            finish_seen_d = 1'b1;
        end else begin
            finish_seen_d = finish_seen_q;
        end

        if (push_s && (req_class == CLS_BEQ) && req_imm[0]) begin
            misalign_d = 1'b1;
        end else begin
            misalign_d = misalign_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    addr_d  = BASE_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (start) begin
                    addr_d = BASE_ADDR;
                end else begin
                    if (pop_s) begin
                        addr_d = addr_q + AW'(4);
                    end else begin
                        addr_d = addr_q;
                    end
                    if (finish_seen_q && drain_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    addr_d  = BASE_ADDR;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = BASE_ADDR;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= BASE_ADDR;
            finish_seen_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            finish_seen_q <= finish_seen_d;
            misalign_q    <= misalign_d;
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench: expected words queued on acceptance, compared on each memory write.
module tb_instr_encode_loader;
    import riscv_pkg::*;

    logic         clk = 1'b0;
    logic         reset, start, finish, req_valid, req_ready;
    instr_class_t req_class;
    logic [4:0]   req_rd, req_rs1, req_rs2;
    logic [2:0]   req_funct3;
    logic [6:0]   req_funct7;
    logic [12:0]  req_imm;
    logic         imem_we, imem_ready, done, imm_misalign;
    logic [31:0]  imem_addr, imem_wdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] cur_word = 32'h0;
    logic        accepted = 1'b0;
    logic        wrote    = 1'b0;

    always #5 clk = ~clk;

    instr_encode_loader #(.DEPTH(4), .AW(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .req_valid(req_valid), .req_ready(req_ready), .req_class(req_class),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .done(done), .imm_misalign(imm_misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // One clock: sample the cycle's transfer 1ns after negedge, then move to the next negedge
    task automatic tick();
        logic [31:0] e;
        #1;
        wrote    = imem_we && imem_ready;
        accepted = req_valid && req_ready;
        if (wrote) begin
            n_writes++;
            chk("write_has_expectation", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", imem_addr, exp_addr);
                chk("wr_data", imem_wdata, e);
            end
            exp_addr = exp_addr + 32'd4;
        end
        if (accepted) exp_q.push_back(cur_word);
        if (start || reset) exp_addr = 32'h0;
        if (reset) exp_q.delete();
        @(negedge clk);
    endtask

    task automatic send(input instr_class_t cls, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [12:0] imm, input logic [31:0] w);
        int guard;
        guard      = 0;
        req_class  = cls;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_funct3 = f3;
        req_funct7 = f7;
        req_imm    = imm;
        cur_word   = w;
        req_valid  = 1'b1;
        do begin
            tick();
            guard++;
        end while (!accepted && guard < 40);
        chk("accept_timeout", {31'd0, accepted}, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 60) begin
            tick();
            guard++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Independent R-type field placement
    function automatic logic [31:0] model_r(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [2:0] f3,
                                            input logic [6:0] f7);
        logic [31:0] w;
        w[6:0]   = 7'h33;
        w[11:7]  = rd;
        w[14:12] = f3;
        w[19:15] = rs1;
        w[24:20] = rs2;
        w[31:25] = f7;
        return w;
    endfunction

    initial begin
        int wbase;
        logic [4:0] a, b, c;
        logic [2:0] f3;
        logic [6:0] f7;
        reset = 1'b1; start = 1'b0; finish = 1'b0; req_valid = 1'b0;
        req_class = CLS_RTYPE; req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0;
        req_funct3 = 3'd0; req_funct7 = 7'd0; req_imm = 13'd0; imem_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_imem_wdata", imem_wdata, 32'h0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_misalign", {31'd0, imm_misalign}, 32'd0);

        // Single R-type, one-cycle latency
        pulse_start();
        send(CLS_RTYPE, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 32'h002081B3);
        #1;
        chk("latency_we", {31'd0, imem_we}, 32'd1);
        drain();

        // LOAD then STORE back to back from address 0
        pulse_start();
        send(CLS_LOAD, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 13'd8, 32'h00812283);
        send(CLS_STORE, 5'd0, 5'd2, 5'd6, 3'd0, 7'd0, 13'd12, 32'h00612623);
        chk("ld_write_during_st_accept", {31'd0, wrote}, 32'd1);
        tick();
        chk("st_write_next_cycle", {31'd0, wrote}, 32'd1);
        chk("ldst_queue_empty", 32'(exp_q.size()), 32'd0);

        // BEQ, aligned then misaligned immediate
        send(CLS_BEQ, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FFC, 32'hFE208EE3);
        drain();
        chk("beq_aligned_flag", {31'd0, imm_misalign}, 32'd0);
        send(CLS_BEQ, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FFD, 32'hFE208EE3);
        drain();
        chk("beq_misalign_set", {31'd0, imm_misalign}, 32'd1);
        tick(); tick(); tick();
        chk("beq_misalign_sticky", {31'd0, imm_misalign}, 32'd1);

        // Back-pressure: fill FIFO while memory stalls
        imem_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            a = 5'(i + 1); b = 5'(i + 7); c = 5'(i + 13); f3 = 3'(i);
            f7 = (i % 2 == 1) ? 7'h20 : 7'h00;
            send(CLS_RTYPE, a, b, c, f3, f7, 13'd0, model_r(a, b, c, f3, f7));
        end
        #1;
        chk("full_ready_low", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b1;
        tick();
        tick();
        chk("full_no_accept", {31'd0, accepted}, 32'd0);
        chk("stall_addr_held", imem_addr, 32'h0);
        imem_ready = 1'b1;
        send(CLS_RTYPE, 5'd31, 5'd30, 5'd29, 3'd7, 7'h7F, 13'd0,
             model_r(5'd31, 5'd30, 5'd29, 3'd7, 7'h7F));
        drain();

        // finish with two entries pending
        pulse_start();
        imem_ready = 1'b0;
        send(CLS_LOAD, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 13'd8, 32'h00812283);
        send(CLS_STORE, 5'd0, 5'd2, 5'd6, 3'd0, 7'd0, 13'd12, 32'h00612623);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        imem_ready = 1'b1;
        tick();
        chk("fin_write1", {31'd0, wrote}, 32'd1);
        #1;
        chk("done_low_on_last_write", {31'd0, done}, 32'd0);
        tick();
        chk("fin_write2", {31'd0, wrote}, 32'd1);
        #1;
        chk("done_after_last_write", {31'd0, done}, 32'd1);
        chk("done_we_low", {31'd0, imem_we}, 32'd0);
        pulse_start();
        #1;
        chk("restart_addr", imem_addr, 32'h0);
        chk("restart_done", {31'd0, done}, 32'd0);

        // Reset with three entries queued
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 5'(i + 20);
            send(CLS_RTYPE, a, 5'd1, 5'd1, 3'd0, 7'd0, 13'd0, model_r(a, 5'd1, 5'd1, 3'd0, 7'd0));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_we", {31'd0, imem_we}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_misalign", {31'd0, imm_misalign}, 32'd0);
        imem_ready = 1'b1;
        pulse_start();
        wbase = n_writes;
        repeat (5) tick();
        chk("no_stale_writes", 32'(n_writes - wbase), 32'd0);
        send(CLS_RTYPE, 5'd9, 5'd8, 5'd7, 3'd4, 7'd0, 13'd0, model_r(5'd9, 5'd8, 5'd7, 3'd4, 7'd0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Converts decoded instruction descriptors into 32-bit RV32I machine words. Descriptor = class, register indices, funct fields, immediate.
- Encodes exactly the four classes the main control unit decodes: R-type, load word, store word, beq.
- Buffers encoded words in a small FIFO and writes them sequentially into instruction memory through a simple write port.
- Used by the test/boot path to load programs into the single-cycle core's instruction memory.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- AW, 32, instruction-memory byte-address width.
- BASE_ADDR, 0, first write address after start; must be word aligned.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: load imem_addr with BASE_ADDR and clear done; FIFO contents kept.
- finish  in  1  pulse: no more descriptors follow; done asserts once the FIFO drains.
- req_valid  in  1  descriptor valid.
- req_ready  out  1  encoder can accept (FIFO not full).
- req_class  in  2  instr_class_t: 0 RTYPE, 1 LOAD, 2 STORE, 3 BEQ.
- req_rd, req_rs1, req_rs2  in  5 each  register indices.
- req_funct3  in  3  used for RTYPE only.
- req_funct7  in  7  used for RTYPE only.
- req_imm  in  13  signed immediate; bits [11:0] for LOAD/STORE, [12:1] for BEQ.
- imem_we  out  1  write strobe.
- imem_ready  in  1  memory accepts the write this cycle.
- imem_addr  out  AW  byte address of the current write.
- imem_wdata  out  32  encoded word.
- done  out  1  level; program fully written.
- imm_misalign  out  1  sticky; a BEQ was accepted with req_imm[0]=1.

Behaviour:
- Reset values: req_ready=1, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, done=0, imm_misalign=0. FIFO empty, FSM=IDLE.
- Accept rule: a descriptor is taken when req_valid & req_ready at the clock edge. It is encoded combinationally and pushed into the FIFO that edge.
- Encodings (fields listed MSB to LSB):
  - RTYPE: funct7|rs2|rs1|funct3|rd|0110011.
  - LOAD: imm[11:0]|rs1|010|rd|0000011.
  - STORE: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
  - BEQ: imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|1100011.
  - Unused descriptor fields are ignored.
- BEQ with imm[0]=1: imm[0] is dropped and imm_misalign is set. The flag clears only on reset.
- FIFO:
  - Pointer width log2(DEPTH)+1; pointers wrap modulo 2·DEPTH.
  - req_ready = !full.
  - Simultaneous push and pop when full is not possible, because ready is deasserted. Simultaneous push and pop when non-full and non-empty keeps the count unchanged.
- FSM states: IDLE, RUN, DONE.
  - IDLE: imem_we=0. On start → RUN, imem_addr=BASE_ADDR. Descriptors may still be accepted and buffered.
  - RUN: imem_we = !empty and imem_wdata = FIFO head, with no extra register stage. When imem_we & imem_ready: pop, and imem_addr += 4 (wraps modulo 2^AW). When imem_ready=0: addr and wdata are held.
  - Going to DONE from RUN: requires finish_seen=1 and FIFO empty. finish_seen is set by a finish pulse and cleared by start. If finish arrives while the last entry is being written, DONE is entered on the following cycle.
  - DONE: done=1, imem_we=0. start → RUN and clears done. Descriptors accepted in DONE are buffered and written only after the next start.
- start while RUN: address restarts at BASE_ADDR, finish_seen clears, FIFO is untouched; any in-flight write completes at the old address that cycle.
- start and finish in the same cycle: start wins, and finish_seen is set to 1.
- Reset mid-operation: the FIFO is flushed and all outputs return to their reset values next edge.
- Latency: a descriptor accepted at edge N into an empty FIFO while in RUN appears on imem_we/imem_wdata during cycle N+1.

Decomposition:
- Package riscv_pkg:
  - instr_class_t enum.
  - Opcode constants OP_RTYPE=7'b0110011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011.
  - F3_LW/F3_SW=3'b010, F3_BEQ=3'b000.
  - The same package is shared with mainControlUnit so both ends agree on the opcodes.
- Sub-module sync_fifo (WIDTH=32, DEPTH). The encoder stays a combinational function inside the top module.

Test Plan:
- start, then push RTYPE rd=3 rs1=1 rs2=2 f3=0 f7=0 → one write: addr 0x0, data 0x002081B3.
- Push LOAD rd=5 rs1=2 imm=8, then STORE rs2=6 rs1=2 imm=12 → data 0x00812283 at addr 0x0, then 0x00612623 at 0x4, on consecutive cycles.
- Push BEQ rs1=1 rs2=2 imm=-4 (13'h1FFC) → 0xFE208EE3. Repeat with imm=13'h1FFD → same word, imm_misalign=1 and sticky.
- Hold imem_ready=0 and push 5 descriptors with DEPTH=4 → req_ready=0 after 4 accepted. Release imem_ready → 4 writes to 0x0..0xC with order preserved, and the 5th is accepted once a slot frees.
- finish while 2 entries remain → done=1 exactly one cycle after the last write, imem_we=0. A second start → addr back to 0x0 and done=0.
- Assert reset with 3 entries queued in RUN → next cycle imem_we=0, req_ready=1, imem_addr=BASE_ADDR, imm_misalign=0, and no stale writes after a new start.
